// File: rtl/class_hbkt_cmp_mt.sv
// Multi-table hash-bucket comparator: signature match, first-free search and an
// in-order result FIFO with credit flow control. CLASS_HBKT_STATS_EN adds pop statistics.
module class_hbkt_cmp_mt #(
  parameter int NUM_TBL    = 2,
  parameter int SLOTS      = 4,
  parameter int SIG_WIDTH  = 16,
  parameter int PTR_WIDTH  = 15,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int ENT_W  = 1 + SIG_WIDTH + PTR_WIDTH,
  localparam int BKT_W  = SLOTS * ENT_W,
  localparam int TBL_W  = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1,
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [SIG_WIDTH-1:0]     in_sig,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  input  logic [NUM_TBL*BKT_W-1:0] in_bkt,
  output logic                     res_vld,
  input  logic                     res_rdy,
  output logic [TAG_WIDTH-1:0]     res_tag,
  output logic                     res_hit,
  output logic                     res_err,
  output logic [PTR_WIDTH-1:0]     res_ptr,
  output logic [TBL_W-1:0]         res_tbl,
  output logic [SLOT_W-1:0]        res_slot,
  output logic                     res_free_vld,
  output logic [TBL_W-1:0]         res_free_tbl,
  output logic [SLOT_W-1:0]        res_free_slot
`ifdef CLASS_HBKT_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [31:0]              stat_lu_cnt,
  output logic [31:0]              stat_hit_cnt,
  output logic [31:0]              stat_err_cnt
`endif
);

  localparam int NUM_ENT = NUM_TBL * SLOTS;
  localparam int RES_W   = 3 + PTR_WIDTH + 2 * TBL_W + 2 * SLOT_W + TAG_WIDTH;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = AW + 1;
  localparam int UW      = CW + 2;

  logic                     r_in_rdy;
  logic                     r_res_vld;
  logic                     w_acc;
  logic                     w_push;
  logic                     w_pop;

  logic                     r_s1_vld;
  logic [SIG_WIDTH-1:0]     r_s1_sig;
  logic [TAG_WIDTH-1:0]     r_s1_tag;
  logic [NUM_TBL*BKT_W-1:0] r_s1_bkt;

  logic [NUM_ENT-1:0]       w_match;
  logic [NUM_ENT-1:0]       w_free;

  logic                     r_s2_vld;
  logic [TAG_WIDTH-1:0]     r_s2_tag;
  logic [NUM_ENT-1:0]       r_s2_match;
  logic [NUM_ENT-1:0]       r_s2_free;
  logic [PTR_WIDTH-1:0]     r_s2_ptr [NUM_ENT];

  logic                     w_hit;
  logic                     w_err;
  logic [PTR_WIDTH-1:0]     w_ptr;
  logic [TBL_W-1:0]         w_tbl;
  logic [SLOT_W-1:0]        w_slot;
  logic                     w_fvld;
  logic [TBL_W-1:0]         w_ftbl;
  logic [SLOT_W-1:0]        w_fslot;
  logic [RES_W-1:0]         w_res;

  logic [RES_W-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_cnt;
  logic [CW-1:0]            w_cnt_nxt;
  logic [UW-1:0]            w_used_nxt;
  logic [RES_W-1:0]         w_head;

  assign w_acc  = in_vld & r_in_rdy;
  assign w_push = r_s2_vld;
  assign w_pop  = r_res_vld & res_rdy;

  // Pipeline stage valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_acc;
      r_s2_vld <= r_s1_vld;
    end
  end

  // S1 payload capture on accept
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_s1_sig <= in_sig;
      r_s1_tag <= in_tag;
      r_s1_bkt <= in_bkt;
    end
  end

  // Per-slot match and free flags, flat index = table*SLOTS + slot
  always_comb begin
    w_match = '0;
    w_free  = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      w_free[i]  = ~r_s1_bkt[i*ENT_W + ENT_W - 1];
      w_match[i] = r_s1_bkt[i*ENT_W + ENT_W - 1] &
                   (r_s1_bkt[i*ENT_W + PTR_WIDTH +: SIG_WIDTH] == r_s1_sig);
    end
  end

  // S2 payload capture
  always_ff @(posedge clk) begin
    if (r_s1_vld) begin
      r_s2_tag   <= r_s1_tag;
      r_s2_match <= w_match;
      r_s2_free  <= w_free;
      for (int i = 0; i < NUM_ENT; i++) begin
        r_s2_ptr[i] <= r_s1_bkt[i*ENT_W +: PTR_WIDTH];
      end
    end
  end

  // Scan from the highest index down so the lowest matching/free index is left standing;
  // a match seen while another is already recorded flags the multi-hit error.
  always_comb begin
    w_hit   = 1'b0;
    w_err   = 1'b0;
    w_ptr   = '0;
    w_tbl   = '0;
    w_slot  = '0;
    w_fvld  = 1'b0;
    w_ftbl  = '0;
    w_fslot = '0;
    for (int t = NUM_TBL - 1; t >= 0; t--) begin
      for (int s = SLOTS - 1; s >= 0; s--) begin
        w_err   = w_err | (r_s2_match[t*SLOTS + s] & w_hit);
        w_ptr   = r_s2_match[t*SLOTS + s] ? r_s2_ptr[t*SLOTS + s] : w_ptr;
        w_tbl   = r_s2_match[t*SLOTS + s] ? TBL_W'(t) : w_tbl;
        w_slot  = r_s2_match[t*SLOTS + s] ? SLOT_W'(s) : w_slot;
        w_hit   = w_hit | r_s2_match[t*SLOTS + s];
        w_ftbl  = r_s2_free[t*SLOTS + s] ? TBL_W'(t) : w_ftbl;
        w_fslot = r_s2_free[t*SLOTS + s] ? SLOT_W'(s) : w_fslot;
        w_fvld  = w_fvld | r_s2_free[t*SLOTS + s];
      end
    end
  end

  assign w_res = {w_hit, w_err, w_ptr, w_tbl, w_slot, w_fvld, w_ftbl, w_fslot, r_s2_tag};

  // Result storage write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_res;
    end
  end

  // Next occupancy and credit; credit counts next FIFO fill plus next in-flight stages
  always_comb begin
    if (w_push && !w_pop) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
    w_used_nxt = UW'(w_cnt_nxt) + UW'(w_acc) + UW'(r_s1_vld);
  end

  // FIFO pointers, occupancy and registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_res_vld <= 1'b0;
      r_in_rdy  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_cnt     <= w_cnt_nxt;
      r_res_vld <= (w_cnt_nxt != '0);
      r_in_rdy  <= (w_used_nxt < UW'(FIFO_DEPTH));
    end
  end

  // Head entry is zeroed when empty so the unreset storage never leaks out
  assign w_head  = r_res_vld ? r_mem[r_rd_ptr] : '0;
  assign {res_hit, res_err, res_ptr, res_tbl, res_slot,
          res_free_vld, res_free_tbl, res_free_slot, res_tag} = w_head;
  assign res_vld = r_res_vld;
  assign in_rdy  = r_in_rdy;

`ifdef CLASS_HBKT_STATS_EN
  logic [31:0] r_lu_cnt;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_err_cnt;

  function automatic logic [31:0] f_sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Saturating pop statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt  <= 32'd0;
      r_hit_cnt <= 32'd0;
      r_err_cnt <= 32'd0;
    end else if (stat_clr) begin
      r_lu_cnt  <= 32'd0;
      r_hit_cnt <= 32'd0;
      r_err_cnt <= 32'd0;
    end else begin
      r_lu_cnt  <= f_sat_inc(r_lu_cnt, w_pop);
      r_hit_cnt <= f_sat_inc(r_hit_cnt, w_pop & res_hit);
      r_err_cnt <= f_sat_inc(r_err_cnt, w_pop & res_err);
    end
  end

  assign stat_lu_cnt  = r_lu_cnt;
  assign stat_hit_cnt = r_hit_cnt;
  assign stat_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_class_hbkt_cmp_mt.sv
// Self-checking bench for class_hbkt_cmp_mt: queue-based result model plus directed tests.
module tb_class_hbkt_cmp_mt;
  localparam int NUM_TBL = 2, SLOTS = 4, SIG_WIDTH = 16, PTR_WIDTH = 15, TAG_WIDTH = 4, FIFO_DEPTH = 8;
  localparam int ENT_W = 1 + SIG_WIDTH + PTR_WIDTH;
  localparam int BKT_W = SLOTS * ENT_W;
  localparam int TBL_W = 1, SLOT_W = 2;
  localparam int NE = NUM_TBL * SLOTS;
  localparam int RES_W = 3 + PTR_WIDTH + 2 * TBL_W + 2 * SLOT_W + TAG_WIDTH;

  logic clk, rst_n, in_vld, in_rdy, res_vld, res_rdy;
  logic [SIG_WIDTH-1:0] in_sig;
  logic [TAG_WIDTH-1:0] in_tag, res_tag;
  logic [NUM_TBL*BKT_W-1:0] in_bkt, bkt;
  logic res_hit, res_err, res_free_vld;
  logic [PTR_WIDTH-1:0] res_ptr;
  logic [TBL_W-1:0] res_tbl, res_free_tbl;
  logic [SLOT_W-1:0] res_slot, res_free_slot;
`ifdef CLASS_HBKT_STATS_EN
  logic stat_clr;
  logic [31:0] stat_lu_cnt, stat_hit_cnt, stat_err_cnt;
`endif

  class_hbkt_cmp_mt #(.NUM_TBL(NUM_TBL), .SLOTS(SLOTS), .SIG_WIDTH(SIG_WIDTH), .PTR_WIDTH(PTR_WIDTH),
                      .TAG_WIDTH(TAG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_sig(in_sig), .in_tag(in_tag),
    .in_bkt(in_bkt), .res_vld(res_vld), .res_rdy(res_rdy), .res_tag(res_tag), .res_hit(res_hit),
    .res_err(res_err), .res_ptr(res_ptr), .res_tbl(res_tbl), .res_slot(res_slot),
    .res_free_vld(res_free_vld), .res_free_tbl(res_free_tbl), .res_free_slot(res_free_slot)
`ifdef CLASS_HBKT_STATS_EN
    , .stat_clr(stat_clr), .stat_lu_cnt(stat_lu_cnt), .stat_hit_cnt(stat_hit_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int k;
  int base;
  int cyc;
  logic acc;
  logic [RES_W-1:0] expq[$];
  logic [RES_W-1:0] act;

  assign act = {res_hit, res_err, res_ptr, res_tbl, res_slot, res_free_vld, res_free_tbl, res_free_slot, res_tag};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: collect matching and free positions in scan order, then read off the first ones
  function automatic logic [RES_W-1:0] model(input logic [SIG_WIDTH-1:0] sig,
                                              input logic [NUM_TBL*BKT_W-1:0] b,
                                              input logic [TAG_WIDTH-1:0] tag);
    int hits[$];
    int frees[$];
    logic [ENT_W-1:0] e;
    logic [PTR_WIDTH-1:0] p;
    logic [TBL_W-1:0] t, ft;
    logic [SLOT_W-1:0] s, fs;
    for (int i = 0; i < NE; i++) begin
      e = b[i*ENT_W +: ENT_W];
      if (e[ENT_W-1] && (e[ENT_W-2 -: SIG_WIDTH] == sig)) hits.push_back(i);
      if (!e[ENT_W-1]) frees.push_back(i);
    end
    p = '0; t = '0; s = '0; ft = '0; fs = '0;
    if (hits.size() > 0) begin
      p = b[hits[0]*ENT_W +: PTR_WIDTH];
      t = TBL_W'(hits[0] / SLOTS);
      s = SLOT_W'(hits[0] % SLOTS);
    end
    if (frees.size() > 0) begin
      ft = TBL_W'(frees[0] / SLOTS);
      fs = SLOT_W'(frees[0] % SLOTS);
    end
    return {hits.size() > 0, hits.size() > 1, p, t, s, frees.size() > 0, ft, fs, tag};
  endfunction

  task automatic set_ent(input int t, input int s, input logic v, input logic [SIG_WIDTH-1:0] sg,
                         input logic [PTR_WIDTH-1:0] p);
    bkt[(t*SLOTS + s)*ENT_W +: ENT_W] = {v, sg, p};
  endtask

  // Drive one request (called at posedge+1) and hold it until accepted; returns cycles taken
  task automatic send(input logic [SIG_WIDTH-1:0] sg, input logic [TAG_WIDTH-1:0] tg, output int n);
    logic a;
    in_sig = sg; in_tag = tg; in_bkt = bkt; in_vld = 1'b1;
    a = 1'b0;
    n = 0;
    while (!a && n < 60) begin
      @(negedge clk);
      a = in_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    if (!a) check("send_timeout", 0, 1);
    in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((expq.size() != 0 || res_vld) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", expq.size(), 0);
  endtask

  // Model bookkeeping at the active edge: pops then accepts
  always @(posedge clk) begin
    if (rst_n) begin
      if (res_vld && res_rdy && expq.size() > 0) begin
        void'(expq.pop_front());
        pop_cnt++;
      end
      if (in_vld && in_rdy) expq.push_back(model(in_sig, in_bkt, in_tag));
    end
  end

  // Compare process: every valid result must equal the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n) begin
      check("credit_bound", expq.size() <= FIFO_DEPTH, 1);
      if (res_vld) begin
        if (expq.size() == 0) check("spurious_result", 1, 0);
        else check("result", act, expq[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_sig = '0; in_tag = '0; in_bkt = '0; res_rdy = 1'b1; bkt = '0;
`ifdef CLASS_HBKT_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_res_vld", res_vld, 0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_data", act, 0);
`ifdef CLASS_HBKT_STATS_EN
    check("rst_stats", {stat_lu_cnt, stat_hit_cnt | stat_err_cnt}, 0);
`endif

    // Single lookup with latency
    bkt = '0;
    set_ent(1, 2, 1'b1, 16'hBEEF, 15'h1234);
    check("model_single", model(16'hBEEF, bkt, 4'h1),
          {1'b1, 1'b0, 15'h1234, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'h1});
    in_sig = 16'hBEEF; in_tag = 4'h1; in_bkt = bkt; in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    @(negedge clk); check("lat_cyc1", res_vld, 0);
    @(negedge clk); check("lat_cyc2", res_vld, 0);
    @(negedge clk); check("lat_cyc3", res_vld, 1);
    check("single_ptr", res_ptr, 15'h1234);
    check("single_loc", {res_hit, res_err, res_tbl, res_slot}, {1'b1, 1'b0, 1'b1, 2'd2});
    check("single_free", {res_free_vld, res_free_tbl, res_free_slot}, {1'b1, 1'b0, 2'd0});
    wait_drain();

    // Multi-hit
    bkt = '0;
    set_ent(0, 3, 1'b1, 16'h0001, 15'd5);
    set_ent(1, 0, 1'b1, 16'h0001, 15'd9);
    check("model_multi", model(16'h0001, bkt, 4'h2),
          {1'b1, 1'b1, 15'd5, 1'b0, 2'd3, 1'b1, 1'b0, 2'd0, 4'h2});
    send(16'h0001, 4'h2, cyc);
    wait_drain();

    // Miss with every slot valid
    for (int t = 0; t < NUM_TBL; t++)
      for (int s = 0; s < SLOTS; s++) set_ent(t, s, 1'b1, 16'hAAAA, 15'(t*SLOTS + s + 1));
    check("model_miss", model(16'h5555, bkt, 4'h3), {{(RES_W-TAG_WIDTH){1'b0}}, 4'h3});
    send(16'h5555, 4'h3, cyc);
    wait_drain();

    // Mixed patterns back to back: one accept per clock
    for (int i = 0; i < 10; i++) begin
      for (int t = 0; t < NUM_TBL; t++)
        for (int s = 0; s < SLOTS; s++)
          set_ent(t, s, 1'($urandom_range(0, 1)), 16'($urandom), 15'($urandom));
      if (i % 3 != 0) set_ent(i % NUM_TBL, i % SLOTS, 1'b1, 16'h0100 + 16'(i), 15'(i));
      if (i % 4 == 1) set_ent(1, 3, 1'b1, 16'h0100 + 16'(i), 15'h7FFF);
      send(16'h0100 + 16'(i), 4'(i), cyc);
      check("throughput", cyc, 1);
    end
    wait_drain();

    // Backpressure: 20 requests, only FIFO_DEPTH accepted while stalled
    res_rdy = 1'b0;
    k = 0;
    base = pop_cnt;
    for (int c = 0; c < 60 && k < 20; c++) begin
      if (c == 20) begin
        check("bp_accepted", k, FIFO_DEPTH);
        check("bp_in_rdy", in_rdy, 0);
        res_rdy = 1'b1;
      end
      bkt = '0;
      set_ent((k / SLOTS) % NUM_TBL, k % SLOTS, 1'b1, 16'h2000 + 16'(k), 15'(k));
      in_sig = 16'h2000 + 16'(k); in_tag = 4'(k); in_bkt = bkt; in_vld = 1'b1;
      @(negedge clk);
      acc = in_rdy;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    in_vld = 1'b0;
    check("bp_all_sent", k, 20);
    wait_drain();
    check("bp_all_popped", pop_cnt - base, 20);

    // Asynchronous reset with results queued
    res_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h3000 + 16'(i), 4'(i), cyc);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_queued", {res_vld, 8'(expq.size())}, {1'b1, 8'd3});
    #2;
    rst_n = 1'b0;
    expq.delete();
    #1;
    check("rst_async_vld", res_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_vld", res_vld, 0);
    check("post_rst_rdy", in_rdy, 1);
    res_rdy = 1'b1;
    base = pop_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale", pop_cnt - base, 0);

`ifdef CLASS_HBKT_STATS_EN
    // 10 lookups: 4 hits, one of them multi-hit
    for (int i = 0; i < 10; i++) begin
      bkt = '0;
      if (i < 4) set_ent(1, i, 1'b1, 16'h4000 + 16'(i), 15'(i));
      if (i == 0) set_ent(0, 1, 1'b1, 16'h4000, 15'd77);
      send(16'h4000 + 16'(i), 4'(i), cyc);
    end
    wait_drain();
    check("stat_lu", stat_lu_cnt, 32'd10);
    check("stat_hit", stat_hit_cnt, 32'd4);
    check("stat_err", stat_err_cnt, 32'd1);
    res_rdy = 1'b0;
    send(16'h4000, 4'hA, cyc);
    repeat (3) @(posedge clk);
    #1;
    check("clr_pending", res_vld, 1);
    base = pop_cnt;
    res_rdy = 1'b1;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("clr_popped", pop_cnt - base, 1);
    check("clr_counters", {stat_lu_cnt, stat_hit_cnt, stat_err_cnt}, 0);
    wait_drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
